alu16_issue_stage: RTL and testbench

- Issue/writeback pipeline that feeds the combinational 16-bit ALU and consumes its result.
- Holds an 8x16 register file and accepts one instruction per cycle over a valid/ready handshake.
- Drives registered operands and ALU control to the ALU, then captures S/Overflow/Zero one cycle later into the register file, the flag registers and a result output port with backpressure.

---
 rtl/alu16_issue_stage.sv | 142 ++++++++++++++
 tb/tb_alu16_issue_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_issue_stage.sv
// Issue/writeback stage around an external combinational ALU: 8-entry register
// file, registered ALU operands, and a backpressured result port with flags.
module alu16_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [3:0]                 instr_op,
  input  logic [$clog2(REG_N)-1:0]   instr_rd,
  input  logic [$clog2(REG_N)-1:0]   instr_ra,
  input  logic [$clog2(REG_N)-1:0]   instr_rb,
  input  logic [DATA_W-1:0]          instr_imm,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [3:0]                 alu_ctrl,
  input  logic [DATA_W-1:0]          alu_s,
  input  logic                       alu_overflow,
  input  logic                       alu_zero,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [$clog2(REG_N)-1:0]   res_rd,
  output logic                       res_err,
  output logic                       flag_z,
  output logic                       flag_v,
  output logic                       err_sticky
);

  localparam int         IDX_W      = $clog2(REG_N);
  localparam logic [3:0] OP_ALU_MAX = 4'd11;
  localparam logic [3:0] OP_LDI     = 4'd15;

  logic [DATA_W-1:0] rf_q [REG_N];

  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_ctrl_q;
  logic [3:0]        ex_op_q;
  logic [IDX_W-1:0]  ex_rd_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic              ex_valid_q;

  logic              res_valid_q, res_err_q;
  logic [DATA_W-1:0] res_data_q;
  logic [IDX_W-1:0]  res_rd_q;
  logic              flag_z_q, flag_v_q, err_sticky_q;

  logic              stall, accept, retire;
  logic              ex_is_alu, ex_is_ldi, wb_en;
  logic [DATA_W-1:0] wb_data, opa_d, opb_d;
  logic [3:0]        ctrl_d;

  assign stall       = res_valid_q & ~res_ready;
  assign instr_ready = ~stall;
  assign accept      = instr_valid & instr_ready;
  assign retire      = ex_valid_q & ~stall;

  assign ex_is_alu = (ex_op_q <= OP_ALU_MAX);
  assign ex_is_ldi = (ex_op_q == OP_LDI);
  assign wb_en     = retire & (ex_is_alu | ex_is_ldi);
  assign wb_data   = ex_is_ldi ? ex_imm_q : alu_s;

  // Forward the retiring value so a dependent instruction issues without a bubble
  assign opa_d  = (wb_en && (ex_rd_q == instr_ra)) ? wb_data : rf_q[instr_ra];
  assign opb_d  = (wb_en && (ex_rd_q == instr_rb)) ? wb_data : rf_q[instr_rb];
  assign ctrl_d = (instr_op <= OP_ALU_MAX) ? instr_op : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[ex_rd_q] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_imm_q   <= '0;
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      alu_a_q    <= opa_d;
      alu_b_q    <= opb_d;
      alu_ctrl_q <= ctrl_d;
      ex_op_q    <= instr_op;
      ex_rd_q    <= instr_rd;
      ex_imm_q   <= instr_imm;
      ex_valid_q <= 1'b1;
    end else if (!stall) begin
      ex_valid_q <= 1'b0;
    end
  end

  // Writeback: result port, flags and sticky error all update on retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_rd_q     <= '0;
      res_err_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else if (retire) begin
      res_valid_q <= 1'b1;
      res_rd_q    <= ex_rd_q;
      if (ex_is_alu) begin
        res_data_q <= alu_s;
        res_err_q  <= 1'b0;
        flag_z_q   <= alu_zero;
        flag_v_q   <= alu_overflow;
      end else if (ex_is_ldi) begin
        res_data_q <= ex_imm_q;
        res_err_q  <= 1'b0;
      end else begin
        res_data_q   <= '0;
        res_err_q    <= 1'b1;
        err_sticky_q <= 1'b1;
      end
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_rd     = res_rd_q;
  assign res_err    = res_err_q;
  assign flag_z     = flag_z_q;
  assign flag_v     = flag_v_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_alu16_issue_stage.sv
// Bench for alu16_issue_stage: behavioural ALU, in-order reference model and a
// result scoreboard fed at instruction accept, drained at result handshake.
module tb_alu16_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic [15:0] instr_imm;
  logic [15:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_ctrl;
  logic        alu_overflow, alu_zero;
  logic        res_valid, res_ready, res_err;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        flag_z, flag_v, err_sticky;

  alu16_issue_stage #(.DATA_W(16), .REG_N(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
    .instr_rb(instr_rb), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_s(alu_s), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err),
    .flag_z(flag_z), .flag_v(flag_v), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // ALU ops: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 A, 11 B
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        v;
    s = '0;
    v = 1'b0;
    case (op)
      4'd0:  s = a & b;
      4'd1:  s = a | b;
      4'd2:  begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd3:  begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd4:  s = a ^ b;
      4'd5:  s = ~(a | b);
      4'd6:  s = {15'd0, $signed(a) < $signed(b)};
      4'd7:  s = a << b[3:0];
      4'd8:  s = a >> b[3:0];
      4'd9:  s = 16'($signed(a) >>> b[3:0]);
      4'd10: s = a;
      4'd11: s = b;
      default: s = '0;
    endcase
    return {v, s};
  endfunction

  logic [16:0] alu_res;
  assign alu_res      = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_s        = alu_res[15:0];
  assign alu_overflow = alu_res[16];
  assign alu_zero     = (alu_res[15:0] == 16'd0);

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        err;
    logic        z;
    logic        v;
    logic        sticky;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    logic [15:0] exp_data;
    logic        exp_z;
    logic        exp_v;
  } vec_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] ref_rf [8];
  logic        ref_z, ref_v, ref_sticky;
  int          checks = 0;
  int          failures = 0;
  logic        rand_bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_reset();
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    ref_z = 1'b0;
    ref_v = 1'b0;
    ref_sticky = 1'b0;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic [15:0] imm);
    exp_t        e;
    logic [16:0] r;
    e.rd  = rd;
    e.err = 1'b0;
    if (op <= 4'd11) begin
      r = alu_fn(op, ref_rf[ra], ref_rf[rb]);
      ref_rf[rd] = r[15:0];
      ref_z = (r[15:0] == 16'd0);
      ref_v = r[16];
      e.data = r[15:0];
    end else if (op == 4'd15) begin
      ref_rf[rd] = imm;
      e.data = imm;
    end else begin
      e.data = '0;
      e.err = 1'b1;
      ref_sticky = 1'b1;
    end
    e.z = ref_z;
    e.v = ref_v;
    e.sticky = ref_sticky;
    return e;
  endfunction

  // Drive one instruction; push its expectation on the cycle it is accepted
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [15:0] imm, input exp_t e);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (instr_ready) begin
        sbq.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
    end
    failures++;
    $display("FAIL issue_timeout instr_ready stuck low, expected high within 200 cycles");
    $fatal(1, "issue timeout");
  endtask

  task automatic idle();
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_pending", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result res_data=%0h res_rd=%0d expected no result", res_data, res_rd);
      end else begin
        mon_e = sbq.pop_front();
        chk("res_data", res_data, mon_e.data);
        chk("res_rd", res_rd, mon_e.rd);
        chk("res_err", res_err, mon_e.err);
        chk("flag_z", flag_z, mon_e.z);
        chk("flag_v", flag_v, mon_e.v);
        chk("err_sticky", err_sticky, mon_e.sticky);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  vec_t tab[14];
  exp_t e;
  logic [3:0] rop;

  initial begin
    tab[0]  = '{4'd15, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0};
    tab[1]  = '{4'd15, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0003, 1'b0, 1'b0};
    tab[2]  = '{4'd2,  3'd3, 3'd1, 3'd2, 16'h0000, 16'h0008, 1'b0, 1'b0};
    tab[3]  = '{4'd15, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tab[4]  = '{4'd15, 3'd2, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tab[5]  = '{4'd3,  3'd3, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tab[6]  = '{4'd2,  3'd4, 3'd1, 3'd2, 16'h0000, 16'hFFFE, 1'b0, 1'b1};
    tab[7]  = '{4'd15, 3'd1, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b1};
    tab[8]  = '{4'd2,  3'd1, 3'd1, 3'd1, 16'h0000, 16'h0002, 1'b0, 1'b0};
    tab[9]  = '{4'd2,  3'd1, 3'd1, 3'd1, 16'h0000, 16'h0004, 1'b0, 1'b0};
    tab[10] = '{4'd2,  3'd1, 3'd1, 3'd1, 16'h0000, 16'h0008, 1'b0, 1'b0};
    tab[11] = '{4'd2,  3'd1, 3'd1, 3'd1, 16'h0000, 16'h0010, 1'b0, 1'b0};
    tab[12] = '{4'd0,  3'd6, 3'd4, 3'd3, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tab[13] = '{4'd4,  3'd7, 3'd4, 3'd1, 16'h0000, 16'hFFEE, 1'b0, 1'b0};

    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0;
    res_ready = 1'b1;
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_flags", {flag_z, flag_v, err_sticky}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_instr_ready", instr_ready, 1);
    @(posedge clk);
    #1;

    // Load/add, zero/overflow flags, double bypass: back-to-back table vectors
    for (int i = 0; i < 14; i++) begin
      e = model(tab[i].op, tab[i].rd, tab[i].ra, tab[i].rb, tab[i].imm);
      e.data = tab[i].exp_data;
      e.z = tab[i].exp_z;
      e.v = tab[i].exp_v;
      issue(tab[i].op, tab[i].rd, tab[i].ra, tab[i].rb, tab[i].imm, e);
    end
    idle();
    drain();

    // Backpressure with a bypassed consumer held at the input
    issue(4'd15, 3'd5, 3'd0, 3'd0, 16'h1234, model(4'd15, 3'd5, 3'd0, 3'd0, 16'h1234));
    res_ready = 1'b0;
    issue(4'd2, 3'd6, 3'd5, 3'd5, 16'h0000, model(4'd2, 3'd6, 3'd5, 3'd5, 16'h0000));
    instr_valid = 1'b1;
    instr_op = 4'd1; instr_rd = 3'd7; instr_ra = 3'd6; instr_rb = 3'd5; instr_imm = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_instr_ready", instr_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 16'h1234);
      chk("bp_alu_ab", {alu_a, alu_b}, {16'h1234, 16'h1234});
      chk("bp_alu_ctrl", alu_ctrl, 4'd2);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    issue(4'd1, 3'd7, 3'd6, 3'd5, 16'h0000, model(4'd1, 3'd7, 3'd6, 3'd5, 16'h0000));
    issue(4'd1, 3'd6, 3'd6, 3'd6, 16'h0000, model(4'd1, 3'd6, 3'd6, 3'd6, 16'h0000));
    idle();
    drain();

    // Illegal opcode immediately followed by a read of its destination
    issue(4'd13, 3'd5, 3'd1, 3'd2, 16'h0000, model(4'd13, 3'd5, 3'd1, 3'd2, 16'h0000));
    issue(4'd1, 3'd5, 3'd5, 3'd5, 16'h0000, model(4'd1, 3'd5, 3'd5, 3'd5, 16'h0000));
    idle();
    drain();
    chk("ill_sticky_hold", err_sticky, 1);

    // Asynchronous reset while a result is stalled and EX is occupied
    issue(4'd3, 3'd3, 3'd1, 3'd1, 16'h0000, model(4'd3, 3'd3, 3'd1, 3'd1, 16'h0000));
    res_ready = 1'b0;
    issue(4'd15, 3'd0, 3'd0, 3'd0, 16'hBEEF, model(4'd15, 3'd0, 3'd0, 3'd0, 16'hBEEF));
    idle();
    @(negedge clk);
    chk("pre_rst_state", {res_valid, flag_z, err_sticky}, 3'b111);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_flags", {flag_z, flag_v, err_sticky}, 0);
    chk("midrst_alu_a", alu_a, 0);
    sbq.delete();
    ref_reset();
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++)
      issue(4'd1, 3'(r), 3'(r), 3'(r), 16'h0000, model(4'd1, 3'(r), 3'(r), 3'(r), 16'h0000));
    idle();
    drain();

    // Random instruction stream under random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) rop = 4'(12 + $urandom_range(0, 2));
      else if ($urandom_range(0, 9) < 3) rop = 4'd15;
      else rop = 4'($urandom_range(0, 11));
      instr_rd = 3'($urandom_range(0, 7));
      instr_ra = 3'($urandom_range(0, 7));
      instr_rb = 3'($urandom_range(0, 7));
      instr_imm = 16'($urandom());
      issue(rop, instr_rd, instr_ra, instr_rb, instr_imm,
            model(rop, instr_rd, instr_ra, instr_rb, instr_imm));
    end
    idle();
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    drain();
    chk("final_sticky", err_sticky, ref_sticky);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
